// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_re;
    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_err;
    logic [DATA_W-1:0]        ch_rdata;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_re;
    logic                     mem_wr;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ready;

    // slave: the arbiter; master: requesters plus the memory model around it
    modport slave (
        input  ch_re, ch_wr, ch_addr, ch_wdata, mem_rdata, mem_ready,
        output ch_ready, ch_err, ch_rdata, mem_addr, mem_wdata, mem_re, mem_wr
    );

    modport master (
        output ch_re, ch_wr, ch_addr, ch_wdata, mem_rdata, mem_ready,
        input  ch_ready, ch_err, ch_rdata, mem_addr, mem_wdata, mem_re, mem_wr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel single-outstanding memory port arbiter with timeout
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     pick;
    logic              pick_valid;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant_oh;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_wr;
    logic [CW-1:0]     cnt;
    logic              timeout_hit;

    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              re_r;
    logic              wr_r;
    logic [NUM_CH-1:0] ready_r;
    logic [NUM_CH-1:0] err_r;

    assign req      = bus.ch_re | bus.ch_wr;
    assign grant_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << grant;

    // Descending scan so the candidate closest to the search start is written last and wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (RR_MODE != 0) begin
                idx = (int'(last_grant) + k) % NUM_CH;
            end else begin
                idx = k - 1;
            end
            if (req[idx]) begin
                pick       = GW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == GW'(i)) begin
                sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
                sel_wr    = bus.ch_wr[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_CH - 1);
            cnt        <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            re_r       <= 1'b0;
            wr_r       <= 1'b0;
            ready_r    <= '0;
            err_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= '0;
                    err_r   <= '0;
                    cnt     <= '0;
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        addr_r     <= sel_addr;
                        wdata_r    <= sel_wdata;
                        // A simultaneous read and write request is serviced as a write.
                        wr_r       <= sel_wr;
                        re_r       <= ~sel_wr;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        rdata_r <= bus.mem_rdata;
                        ready_r <= grant_oh;
                        re_r    <= 1'b0;
                        wr_r    <= 1'b0;
                        state   <= DONE;
                    end else if (timeout_hit) begin
                        rdata_r <= '0;
                        ready_r <= grant_oh;
                        err_r   <= grant_oh;
                        re_r    <= 1'b0;
                        wr_r    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ready_r <= '0;
                    err_r   <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_re    = re_r;
    assign bus.mem_wr    = wr_r;
    assign bus.ch_ready  = ready_r;
    assign bus.ch_err    = err_r;
    assign bus.ch_rdata  = rdata_r;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter RR_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles waiting on mem_ready; 0 = no timeout.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port ch_re  input  NUM_CH  per-channel read request.
REQ-009 SHALL have port ch_wr  input  NUM_CH  per-channel write request.
REQ-010 SHALL have port ch_addr  input  NUM_CH*ADDR_W  flattened per-channel address; channel i at [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port ch_wdata  input  NUM_CH*DATA_W  flattened per-channel write data.
REQ-012 SHALL have port ch_ready  output  NUM_CH  one-cycle completion pulse per channel.
REQ-013 SHALL have port ch_err  output  NUM_CH  one-cycle timeout flag, coincident with ch_ready.
REQ-014 SHALL have port ch_rdata  output  DATA_W  read data, shared, valid while any ch_ready bit is high.
REQ-015 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-016 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-017 SHALL have port mem_re / mem_wr  output  1 each  memory read/write strobes.
REQ-018 SHALL have port mem_rdata  input  DATA_W, and mem_ready  input  1, the memory response.

Function
REQ-019 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-020 IDLE: if any ch_re|ch_wr bit is high, SHALL select one channel, register its addr, wdata and op, and go to BUSY next edge; otherwise stay in IDLE.
REQ-021 RR_MODE=0: SHALL grant the lowest-index requesting channel.
REQ-022 RR_MODE=1: SHALL search from (last_grant+1) mod NUM_CH upward with wrap-around; last_grant resets to NUM_CH-1, so channel 0 wins first.
REQ-023 If a channel asserts ch_re and ch_wr together, SHALL perform a write only.
REQ-024 BUSY: SHALL drive mem_addr and mem_wdata from the registered values, and hold exactly one of mem_re or mem_wr high every cycle.
REQ-025 BUSY: on the first cycle mem_ready=1, SHALL capture mem_rdata into ch_rdata and go to DONE.
REQ-026 BUSY: SHALL count cycles; if TIMEOUT!=0 and the count reaches TIMEOUT without mem_ready, SHALL go to DONE with err set and ch_rdata=0.
REQ-027 DONE: SHALL pulse ch_ready[grant] (and ch_err[grant] if timed out) for exactly one cycle, deassert mem_re/mem_wr, then return to IDLE.
REQ-028 Latency: request in IDLE at cycle N -> strobe from N+1 -> mem_ready at cycle M -> ch_ready at M+1; minimum 3 cycles with zero-wait memory.
REQ-029 Requesters SHALL hold their request until ch_ready; a request dropped mid-transaction SHALL NOT abort it, and the ready pulse is still issued.
REQ-030 A channel still requesting in the DONE cycle SHALL NOT be treated as a new request; arbitration occurs only in IDLE, so back-to-back service costs one IDLE cycle.
REQ-031 mem_ready while not in BUSY SHALL be ignored.
REQ-032 No more than one memory transaction SHALL be outstanding at a time.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE; mem_re, mem_wr, ch_ready, ch_err=0; mem_addr, mem_wdata, ch_rdata=0; timeout counter=0; last_grant=NUM_CH-1.
REQ-034 Reset asserted mid-BUSY SHALL abandon the transaction with no ch_ready pulse; strobes are low on the cycle after the reset edge.

Verification
REQ-035 Single read, ch0 addr 0x100, zero-wait memory returns 0xDEADBEEF -> mem_re high 1 cycle; ch_ready[0] pulses at cycle N+2 with ch_rdata=0xDEADBEEF.
REQ-036 RR_MODE=0, ch0 and ch1 both hold reads -> ch0 is serviced first, then ch1; RR_MODE=1 with both held for 4 transactions -> grant order 0,1,0,1.
REQ-037 Write on ch1, addr 0x40, data 0x12345678, mem_ready delayed 5 cycles -> mem_wr held 5 cycles with stable addr/data; ch_ready[1] pulses once; ch_err[1]=0.
REQ-038 TIMEOUT=4, mem_ready never asserted -> mem_re high 4 cycles, then ch_ready[0] and ch_err[0] pulse together with ch_rdata=0, FSM returns to IDLE.
REQ-039 rst=0 during BUSY of a ch0 read -> no ch_ready, strobes low the next cycle; a subsequent ch0 read completes normally.
REQ-040 ch0 asserts re and wr together -> only mem_wr asserted; mem_ready arriving while IDLE -> no ch_ready pulse.
